input_conditioner: RTL and testbench

//  Conditions the raw push-buttons (izq, der, fire) before they reach the game core (Main).
//  Per input: 2-FF synchronizer, then debounce.
//  izq/der: turned into single-cycle crosshair step pulses with hold-to-repeat.

---
 rtl/input_conditioner.sv | 215 +++++++++++++++++++++
 tb/tb_input_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Push-button conditioning for the game core: 2-FF sync + debounce per button,
// step pulses with hold-to-repeat for izq/der, cooldown-limited shot pulses for fire.

module input_conditioner_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sync1_q, sync2_q, level_q, prev_q;
   logic          level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Once the run of mismatching samples hits the limit the level flips,
   // regardless of the sample arriving on that edge.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (cnt_q == CNT_MAX)
         level_d = ~level_q;
      else if (sync2_q != level_q)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = level_q & ~prev_q;
endmodule

module input_conditioner_dir #(
   parameter int REPEAT_DELAY = 15000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   input  logic rise_i,
   input  logic block_i,
   output logic step_o
);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW   = $clog2(RMAX + 1);
   localparam logic [CW-1:0] DLY_LOAD  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RATE_LOAD = CW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          step_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         step_q <= 1'b0;
         // Only a fresh rise leaves IDLE, so a hold that survives a conflict never re-arms.
         if (!level_i || block_i) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (rise_i) begin
                     step_q  <= 1'b1;
                     cnt_q   <= DLY_LOAD;
                     state_q <= S_DELAY;
                  end
               end
               S_DELAY, S_REPEAT: begin
                  if (cnt_q == '0) begin
                     step_q  <= 1'b1;
                     cnt_q   <= RATE_LOAD;
                     state_q <= S_REPEAT;
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign step_o = step_q;
endmodule

module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 15000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int FIRE_COOLDOWN   = 25000000
) (
   input  logic clk,
   input  logic reset,
   input  logic izq,
   input  logic der,
   input  logic fire,
   output logic izq_step,
   output logic der_step,
   output logic fire_pulse,
   output logic fire_ready
);
   localparam int FW = $clog2(FIRE_COOLDOWN + 1);
   localparam logic [FW-1:0] FIRE_LOAD = FW'(FIRE_COOLDOWN - 1);

   logic [2:0] raw, lvl, rise;
   logic       conflict;

   assign raw = {fire, der, izq};

   for (genvar i = 0; i < 3; i++) begin : g_db
      input_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .reset  (reset),
         .raw_i  (raw[i]),
         .level_o(lvl[i]),
         .rise_o (rise[i])
      );
   end

   assign conflict = lvl[0] & lvl[1];

   input_conditioner_dir #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_izq (
      .clk    (clk),
      .reset  (reset),
      .level_i(lvl[0]),
      .rise_i (rise[0]),
      .block_i(conflict),
      .step_o (izq_step)
   );

   input_conditioner_dir #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_der (
      .clk    (clk),
      .reset  (reset),
      .level_i(lvl[1]),
      .rise_i (rise[1]),
      .block_i(conflict),
      .step_o (der_step)
   );

   typedef enum logic [1:0] {F_READY, F_COOL, F_WAIT} fstate_e;

   fstate_e       fstate_q;
   logic [FW-1:0] fcnt_q;
   logic          pulse_q, rdy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fstate_q <= F_READY;
         fcnt_q   <= '0;
         pulse_q  <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         pulse_q <= 1'b0;
         case (fstate_q)
            F_READY: begin
               if (rise[2]) begin
                  pulse_q  <= 1'b1;
                  fcnt_q   <= FIRE_LOAD;
                  fstate_q <= F_COOL;
                  rdy_q    <= 1'b0;
               end
            end
            F_COOL: begin
               if (fcnt_q == '0) begin
                  if (lvl[2]) begin
                     fstate_q <= F_WAIT;
                  end else begin
                     fstate_q <= F_READY;
                     rdy_q    <= 1'b1;
                  end
               end else begin
                  fcnt_q <= fcnt_q - FW'(1);
               end
            end
            F_WAIT: begin
               if (!lvl[2]) begin
                  fstate_q <= F_READY;
                  rdy_q    <= 1'b1;
               end
            end
            default: begin
               fstate_q <= F_READY;
               rdy_q    <= 1'b1;
            end
         endcase
      end
   end

   assign fire_pulse = pulse_q;
   assign fire_ready = rdy_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal timing checks plus
// random button activity compared every cycle against an event-time model.

module tb_input_conditioner;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 3;
   localparam int FC = 8;

   logic clk = 1'b0, reset = 1'b1, izq = 1'b0, der = 1'b0, fire = 1'b0;
   logic izq_step, der_step, fire_pulse, fire_ready;

   input_conditioner #(
      .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIRE_COOLDOWN(FC)
   ) dut (
      .clk(clk), .reset(reset), .izq(izq), .der(der), .fire(fire),
      .izq_step(izq_step), .der_step(der_step), .fire_pulse(fire_pulse), .fire_ready(fire_ready)
   );

   always #5 clk = ~clk;

   // cyc = index of the next rising edge
   int  cyc = 0;
   bit  started = 1'b0;
   bit  [2:0] m_s1, m_s2, m_deb, m_prev;
   int  m_run [3];
   bit  m_pv [2];
   int  m_p [2];
   bit  m_ready = 1'b1;
   int  m_cool_end = 0;
   bit  e_izq, e_der, e_fire, e_ready;
   int  n_vec = 0, n_err = 0;
   int  izq_q[$], der_q[$], fire_q[$];
   bit  rdy_log [0:16383];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc - 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: debounced level from runs of mismatching synced samples; step pulses
   // from elapsed time since the accepted press; fire readiness from cooldown end time.
   initial begin
      bit [2:0] od, op, raw;
      bit       conf;
      bit       es [2];
      int       dt;
      forever begin
         @(posedge clk);
         od   = m_deb;
         op   = m_prev;
         raw  = {fire, der, izq};
         conf = od[0] & od[1];
         for (int i = 0; i < 2; i++) begin
            es[i] = 1'b0;
            if (reset || !od[i] || conf) begin
               m_pv[i] = 1'b0;
            end else if (!m_pv[i]) begin
               if (!op[i]) begin
                  m_pv[i] = 1'b1;
                  m_p[i]  = cyc;
                  es[i]   = 1'b1;
               end
            end else begin
               dt    = cyc - m_p[i];
               es[i] = (dt == RD) || (dt > RD && ((dt - RD) % RR) == 0);
            end
         end
         e_izq  = es[0];
         e_der  = es[1];
         e_fire = 1'b0;
         if (reset) begin
            m_ready = 1'b1;
         end else if (m_ready && od[2] && !op[2]) begin
            e_fire     = 1'b1;
            m_ready    = 1'b0;
            m_cool_end = cyc + FC;
         end else if (!m_ready && cyc >= m_cool_end && !od[2]) begin
            m_ready = 1'b1;
         end
         e_ready = m_ready;
         for (int i = 0; i < 3; i++) begin
            if (reset) begin
               m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_prev[i] = 0; m_run[i] = 0;
            end else begin
               m_prev[i] = od[i];
               if (m_run[i] == D) begin
                  m_deb[i] = ~od[i];
                  m_run[i] = 0;
               end else if (m_s2[i] != od[i]) begin
                  m_run[i]++;
               end else begin
                  m_run[i] = 0;
               end
               m_s2[i] = m_s1[i];
               m_s1[i] = raw[i];
            end
         end
         if (reset) started = 1'b1;
         cyc++;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("izq_step",   int'(izq_step),   int'(e_izq));
            check("der_step",   int'(der_step),   int'(e_der));
            check("fire_pulse", int'(fire_pulse), int'(e_fire));
            check("fire_ready", int'(fire_ready), int'(e_ready));
            if (izq_step)   izq_q.push_back(cyc - 1);
            if (der_step)   der_q.push_back(cyc - 1);
            if (fire_pulse) fire_q.push_back(cyc - 1);
            if (cyc - 1 < 16384) rdy_log[cyc - 1] = fire_ready;
         end
      end
   end

   function automatic int qat(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1000;
   endfunction

   initial begin
      int e, e2, n;
      // 1: reset state, and reset holding off a pressed button
      reset = 1'b1;
      repeat (2) tick();
      check("t1_izq_step", int'(izq_step), 0);
      check("t1_der_step", int'(der_step), 0);
      check("t1_fire_pulse", int'(fire_pulse), 0);
      check("t1_fire_ready", int'(fire_ready), 1);
      izq = 1'b1;
      repeat (8) tick();
      izq = 1'b0;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      check("t1_rst_hold_steps", izq_q.size(), 0);

      // 2: hold-to-repeat timing
      izq_q.delete();
      izq = 1'b1; e = cyc;
      repeat (40) tick();
      izq = 1'b0;
      repeat (30) tick();
      check("t2_count", izq_q.size(), 11);
      check("t2_first", qat(izq_q, 0) - e, 7);
      check("t2_delay", qat(izq_q, 1) - e, 17);
      check("t2_rep1",  qat(izq_q, 2) - e, 20);
      check("t2_rep2",  qat(izq_q, 3) - e, 23);
      check("t2_last",  qat(izq_q, 10) - e, 44);

      // 3: glitch rejected, minimum stable press accepted
      der_q.delete();
      der = 1'b1;
      repeat (3) tick();
      der = 1'b0;
      repeat (20) tick();
      check("t3_glitch", der_q.size(), 0);
      der = 1'b1; e = cyc;
      repeat (4) tick();
      der = 1'b0;
      repeat (20) tick();
      check("t3_count", der_q.size(), 1);
      check("t3_lat", qat(der_q, 0) - e, 7);

      // 4: conflict blocks both, no re-arm from hold
      izq_q.delete(); der_q.delete();
      izq = 1'b1; e = cyc;
      repeat (12) tick();
      der = 1'b1;
      repeat (20) tick();
      izq = 1'b0;
      repeat (30) tick();
      check("t4_izq_count", izq_q.size(), 2);
      check("t4_izq_2nd", qat(izq_q, 1) - e, 17);
      check("t4_der_none", der_q.size(), 0);
      der = 1'b0;
      repeat (15) tick();
      der = 1'b1; e2 = cyc;
      repeat (8) tick();
      der = 1'b0;
      repeat (15) tick();
      check("t4_der_repress", der_q.size(), 1);
      check("t4_der_lat", qat(der_q, 0) - e2, 7);

      // 5: held fire -> single shot, readiness waits for release
      fire_q.delete();
      fire = 1'b1; e = cyc;
      repeat (30) tick();
      fire = 1'b0;
      repeat (20) tick();
      check("t5_count", fire_q.size(), 1);
      check("t5_lat", qat(fire_q, 0) - e, 7);
      check("t5_rdy_before", int'(rdy_log[e + 6]), 1);
      check("t5_rdy_drop", int'(rdy_log[e + 7]), 0);
      check("t5_rdy_held", int'(rdy_log[e + 36]), 0);
      check("t5_rdy_back", int'(rdy_log[e + 37]), 1);

      // 6: tap during cooldown dropped, press after ready accepted
      fire_q.delete();
      fire = 1'b1; e = cyc;
      repeat (5) tick();
      fire = 1'b0;
      repeat (4) tick();
      fire = 1'b1;
      repeat (2) tick();
      fire = 1'b0;
      n = 0;
      while (!fire_ready && n < 100) begin
         tick();
         n++;
      end
      check("t6_ready_timeout", int'(n < 100), 1);
      fire = 1'b1; e2 = cyc;
      repeat (10) tick();
      fire = 1'b0;
      repeat (20) tick();
      check("t6_count", fire_q.size(), 2);
      check("t6_first", qat(fire_q, 0) - e, 7);
      check("t6_second", qat(fire_q, 1) - e2, 7);
      check("t6_cool_busy", int'(rdy_log[e + 14]), 0);
      check("t6_cool_done", int'(rdy_log[e + 15]), 1);

      // random activity with occasional resets
      repeat (3000) begin
         tick();
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 11) == 0) izq  = ~izq;
         if ($urandom_range(0, 11) == 0) der  = ~der;
         if ($urandom_range(0, 9)  == 0) fire = ~fire;
      end
      reset = 1'b0; izq = 1'b0; der = 1'b0; fire = 1'b0;
      repeat (40) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
